// File: rtl/drone_pkg.sv
// Shared encodings for the drone plant model: motor/drop codes, default
// station positions and the plant FSM state type.
// Optional feature macro: DRONE_PLANT_FAULT_EN (adds the FAULT state).
package drone_pkg;

  localparam logic [1:0] MOTOR_STOP = 2'b00;
  localparam logic [1:0] MOTOR_UP   = 2'b01;
  localparam logic [1:0] MOTOR_DOWN = 2'b10;
  localparam logic [1:0] MOTOR_ILL  = 2'b11;

  localparam int DROP_BIT5 = 0;
  localparam int DROP_BIT6 = 1;

  localparam int DEF_POS_FS1 = 0;
  localparam int DEF_POS_FS5 = 100;
  localparam int DEF_POS_FS6 = 120;

`ifdef DRONE_PLANT_FAULT_EN
  typedef enum logic [2:0] {
    IDLE, MOVE_UP, MOVE_DOWN, DROP5, DROP6, FAULT
  } plant_state_t;
`else
  typedef enum logic [2:0] {
    IDLE, MOVE_UP, MOVE_DOWN, DROP5, DROP6
  } plant_state_t;
`endif

endpackage

// File: rtl/drone_step_timer.sv
// Movement prescaler: counts 0..STEP_DIV-1 while enabled and emits a
// one-cycle tick on the wrap cycle. clr restarts the count from zero.
module drone_step_timer #(
  parameter int STEP_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);

  logic [CNT_W-1:0] cnt_reg;

  assign tick = en && !clr && (cnt_reg == CNT_LAST);

  // Prescaler count: clear has priority, wraps back to zero on the tick cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= (cnt_reg == CNT_LAST) ? '0 : cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/drone_plant.sv
// Behavioural shaft plant and call panel for the drone delivery controller.
// Integrates Motor into pos, decodes station sensors, times drops into
// Floor5/Floor6 strobes and latches call buttons.
// Optional feature macro: DRONE_PLANT_FAULT_EN (sticky fault output/state).
module drone_plant
  import drone_pkg::*;
#(
  parameter int POS_W       = 8,
  parameter int POS_FS1     = DEF_POS_FS1,
  parameter int POS_FS5     = DEF_POS_FS5,
  parameter int POS_FS6     = DEF_POS_FS6,
  parameter int STEP_DIV    = 4,
  parameter int DROP_CYCLES = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       Motor,
  input  logic [1:0]       Drop,
  input  logic             btn5,
  input  logic             btn6,
  output logic             FS1,
  output logic             FS5,
  output logic             FS6,
  output logic             Floor5,
  output logic             Floor6,
  output logic             Call5,
  output logic             Call6,
`ifdef DRONE_PLANT_FAULT_EN
  output logic             fault,
`endif
  output logic [POS_W-1:0] pos
);

  localparam logic [POS_W-1:0] P1 = POS_W'(POS_FS1);
  localparam logic [POS_W-1:0] P5 = POS_W'(POS_FS5);
  localparam logic [POS_W-1:0] P6 = POS_W'(POS_FS6);
  localparam int DC_W = (DROP_CYCLES > 1) ? $clog2(DROP_CYCLES) : 1;
  localparam logic [DC_W-1:0] DC_LAST = DC_W'(DROP_CYCLES - 1);

  plant_state_t     state_reg, state_next;
  logic [POS_W-1:0] pos_reg;
  logic [DC_W-1:0]  drop_cnt_reg;
  logic             floor5_reg, floor6_reg;
  logic             call5_reg, call6_reg;
  logic             step_en, step_clr, step_tick;
  logic             drop5_done, drop6_done;
  logic             in_drop;

  assign pos    = pos_reg;
  assign FS1    = (pos_reg == P1);
  assign FS5    = (pos_reg == P5);
  assign FS6    = (pos_reg == P6);
  assign Floor5 = floor5_reg;
  assign Floor6 = floor6_reg;
  assign Call5  = call5_reg;
  assign Call6  = call6_reg;

  assign in_drop = (state_reg == DROP5) || (state_reg == DROP6);

  // A drop completes on the cycle its count reaches the last value while
  // the matching Drop bit is still held with the motor stopped.
  assign drop5_done = (state_reg == DROP5) && Drop[DROP_BIT5] &&
                      (Motor == MOTOR_STOP) && (drop_cnt_reg == DC_LAST);
  assign drop6_done = (state_reg == DROP6) && Drop[DROP_BIT6] &&
                      (Motor == MOTOR_STOP) && (drop_cnt_reg == DC_LAST);

  // Next-state decode; Motor=11 is a stop unless the fault option is built in.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (Motor == MOTOR_UP)
          state_next = MOVE_UP;
        else if (Motor == MOTOR_DOWN)
          state_next = MOVE_DOWN;
        else if ((Motor == MOTOR_STOP) && (Drop == 2'b01) && (pos_reg == P5))
          state_next = DROP5;
        else if ((Motor == MOTOR_STOP) && (Drop == 2'b10) && (pos_reg == P6))
          state_next = DROP6;
      end
      MOVE_UP, MOVE_DOWN: begin
        if (Motor == MOTOR_UP)
          state_next = MOVE_UP;
        else if (Motor == MOTOR_DOWN)
          state_next = MOVE_DOWN;
        else
          state_next = IDLE;
      end
      DROP5: begin
        if (!Drop[DROP_BIT5] || (Motor != MOTOR_STOP) || drop5_done)
          state_next = IDLE;
      end
      DROP6: begin
        if (!Drop[DROP_BIT6] || (Motor != MOTOR_STOP) || drop6_done)
          state_next = IDLE;
      end
      default: state_next = state_reg;
    endcase
`ifdef DRONE_PLANT_FAULT_EN
    if ((Motor == MOTOR_ILL) || (Drop == 2'b11) ||
        (in_drop && (Motor != MOTOR_STOP)) || (state_reg == FAULT))
      state_next = FAULT;
`endif
  end

  // Steps only accrue while the move state persists; any transition restarts them.
  assign step_en  = ((state_reg == MOVE_UP) || (state_reg == MOVE_DOWN)) &&
                    (state_next == state_reg);
  assign step_clr = (state_next != state_reg);

  drone_step_timer #(
    .STEP_DIV (STEP_DIV)
  ) u_step_timer (
    .clk   (clk),
    .reset (reset),
    .en    (step_en),
    .clr   (step_clr),
    .tick  (step_tick)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Shaft position integrator, saturating at the bottom and top stations.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos_reg <= P1;
    end else if (step_tick) begin
      if ((state_reg == MOVE_UP) && (pos_reg != P6))
        pos_reg <= pos_reg + 1'b1;
      else if ((state_reg == MOVE_DOWN) && (pos_reg != P1))
        pos_reg <= pos_reg - 1'b1;
    end
  end

  // Drop hold counter: runs only while the drop state is kept, else cleared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      drop_cnt_reg <= '0;
    else if (in_drop && (state_next == state_reg))
      drop_cnt_reg <= drop_cnt_reg + 1'b1;
    else
      drop_cnt_reg <= '0;
  end

  // One-cycle delivery-complete strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      floor5_reg <= 1'b0;
      floor6_reg <= 1'b0;
    end else begin
      floor5_reg <= drop5_done && (state_next == IDLE);
      floor6_reg <= drop6_done && (state_next == IDLE);
    end
  end

  // Call latches: a button press beats the clear from a same-cycle strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      call5_reg <= 1'b0;
      call6_reg <= 1'b0;
    end else begin
      if (btn5)            call5_reg <= 1'b1;
      else if (floor5_reg) call5_reg <= 1'b0;
      if (btn6)            call6_reg <= 1'b1;
      else if (floor6_reg) call6_reg <= 1'b0;
    end
  end

`ifdef DRONE_PLANT_FAULT_EN
  logic fault_reg;
  assign fault = fault_reg;

  // Sticky fault flag, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) fault_reg <= 1'b0;
    else       fault_reg <= fault_reg | (state_next == FAULT);
  end
`endif

endmodule

// File: doc/drone_plant.md
Name: drone_plant

Overview:
Behavioural plant and call-panel model that sits on the far side of the drone delivery controller's interface.
- Consumes Motor[1:0] and Drop[1:0].
- Integrates motor commands into a shaft position.
- Produces station sensors FS1/FS5/FS6 and delivery-complete strobes Floor5/Floor6.
- Latches passenger buttons into Call5/Call6.
Synthesisable; used as the closed-loop partner for controller benches and FPGA demos.

Parameters:
POS_W, 8, position counter width
POS_FS1, 0, station 1 position
POS_FS5, 100, station 5 position
POS_FS6, 120, station 6 position (also position ceiling)
STEP_DIV, 4, clk cycles per one-unit position step (>=1)
DROP_CYCLES, 8, cycles a drop must be held before completion strobe (>=1)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
Motor  in  2  01=up, 10=down, 00=stop, 11=illegal
Drop  in  2  bit0=drop at station 5, bit1=drop at station 6
btn5  in  1  call button station 5, level
btn6  in  1  call button station 6, level
FS1  out  1  high while pos==POS_FS1
FS5  out  1  high while pos==POS_FS5
FS6  out  1  high while pos==POS_FS6
Floor5  out  1  one-cycle delivery-complete strobe, station 5
Floor6  out  1  one-cycle delivery-complete strobe, station 6
Call5  out  1  latched call request, station 5
Call6  out  1  latched call request, station 6
pos  out  POS_W  current shaft position

Behaviour:
- Reset (async, immediate) values:
  - pos=POS_FS1; prescaler=0; drop counter=0; state=IDLE.
  - Call5=Call6=0; Floor5=Floor6=0.
  - FS1=1, FS5=0, FS6=0 (FS outputs are decoded from pos).
- FSM states: IDLE, MOVE_UP, MOVE_DOWN, DROP5, DROP6 (FAULT only with option).
- IDLE transitions:
  - Motor=01 -> MOVE_UP.
  - Motor=10 -> MOVE_DOWN.
  - Motor=00 with Drop=01 and pos==POS_FS5 -> DROP5.
  - Motor=00 with Drop=10 and pos==POS_FS6 -> DROP6.
  - Otherwise stay in IDLE.
- MOVE_UP / MOVE_DOWN:
  - Prescaler counts 0..STEP_DIV-1; on wrap, pos +1 (up) or -1 (down).
  - pos saturates at POS_FS1 (down) and POS_FS6 (up); no wrap-around.
  - Motor change takes effect the next cycle: 00 -> IDLE; reversal -> opposite move state.
  - Prescaler clears on every state change.
- FS outputs are combinational decodes of registered pos. A step to a station asserts its FS output the cycle after the step edge.
- DROP5 / DROP6:
  - Counter increments each cycle while the matching Drop bit stays high and Motor=00.
  - When the count reaches DROP_CYCLES-1, the matching Floor strobe is registered high for exactly one cycle and the state returns to IDLE.
  - Latency: Floor strobe asserts DROP_CYCLES cycles after state entry.
  - Drop released or Motor!=00 before completion -> abort to IDLE, counter=0, no strobe.
- Drop=11, or a drop requested away from the matching station: ignored (stay in IDLE).
- Motor=11: treated as stop (-> IDLE).
- Call latches:
  - Call5 is set by btn5=1 and cleared in the cycle after a Floor5 strobe.
  - If set and clear occur in the same cycle, set wins.
  - Call6 behaves likewise with btn6/Floor6.
- Reset asserted mid-move or mid-drop: all state returns to reset values at once; no strobe is emitted.

Optional Feature:
DRONE_PLANT_FAULT_EN
- Enabled:
  - Adds output fault (1 bit, reset 0).
  - Motor=11, Drop=11, or a move command while in DROP5/6 -> FAULT.
  - FAULT is sticky until reset; pos is frozen, FS outputs stay decoded, and no Floor strobes occur.
- Disabled: no fault port; illegal codes follow the base rules above.

Decomposition:
- Package drone_pkg holds:
  - Motor encodings MOTOR_STOP/UP/DOWN/ILL.
  - Drop bit indices.
  - The plant_state_t enum.
  - Default station positions.
- Sub-module drone_step_timer holds the STEP_DIV prescaler: ports clk, reset, en, clr, tick.

Test Plan:
- Reset release, Motor=01 held, defaults -> pos reaches 100 after 400 cycles, FS5=1; pos reaches 120 after 480 cycles, FS6=1; pos stays 120 thereafter.
- From pos=100, Motor=00, Drop=01 held 8 cycles -> Floor5 pulses high on cycle 8 for 1 cycle; Call5 (set earlier by btn5) clears the next cycle.
- Drop=01 released after 5 cycles -> no Floor5 strobe, state IDLE; re-request -> full 8-cycle count restarts.
- Drop=10 at pos=100 -> ignored, Floor6 stays 0; Motor=10 from 120 for 480 cycles -> pos=0, FS1=1, pos does not underflow.
- btn6 and Floor6 strobe coincident -> Call6 remains 1.
- reset pulsed at pos=57 while moving -> pos=0, FS1=1, outputs at reset values; with DRONE_PLANT_FAULT_EN, Motor=11 -> fault=1 and pos frozen until reset.
